store_buffer: RTL and testbench

- Posted-write buffer between the MEM stage and the data RAM (combinational read, clocked byte-masked write).
- Stores from MEM are queued and retire to RAM in cycles when MEM issues no memory access, so stores do not consume RAM port cycles.
- Loads read RAM directly. Pending buffered bytes are merged into the load result in the same cycle.
- Raises a stall request only when the buffer is full or on a sync request.

---
 rtl/store_buffer_pkg.sv | 30 +++
 rtl/store_buffer_if.sv | 26 ++
 rtl/store_buffer_fwd.sv | 33 +++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants, RAM-port operation encoding and byte-lane helper for the
// posted-write store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_LANES = 4;

  typedef enum logic [1:0] {
    RAM_IDLE  = 2'd0,
    RAM_READ  = 2'd1,
    RAM_WRITE = 2'd2
  } ram_op_e;

  // Overlay the selected byte lanes of upd onto base.
  function automatic logic [SB_DW-1:0] lane_merge(
    input logic [SB_DW-1:0]    base,
    input logic [SB_DW-1:0]    upd,
    input logic [SB_LANES-1:0] sel
  );
    logic [SB_DW-1:0] r;
    r = base;
    for (int l = 0; l < SB_LANES; l++) begin
      if (sel[l]) r[l*8 +: 8] = upd[l*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage side of the store buffer: access request, load result, sync and stall.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);
  logic                mem_ce_i;
  logic                mem_we_i;
  logic [AW-1:0]       mem_addr_i;
  logic [SB_LANES-1:0] mem_sel_i;
  logic [DW-1:0]       mem_data_i;
  logic [DW-1:0]       mem_data_o;
  logic                sync_i;
  logic                stallreq_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, sync_i,
    input  mem_data_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, sync_i,
    output mem_data_o, stallreq_o
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// Load-forwarding merge: each byte lane takes the youngest buffered byte for the
// addressed word, falling back to the RAM read data.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1,
  localparam int WA   = AW - 2
) (
  input  logic [DW-1:0]       ram_data_i,
  input  logic [WA-1:0]       ld_waddr_i,
  input  logic [PW-1:0]       head_i,
  input  logic [CW-1:0]       count_i,
  input  logic [WA-1:0]       ent_addr_i [DEPTH],
  input  logic [SB_LANES-1:0] ent_sel_i  [DEPTH],
  input  logic [DW-1:0]       ent_data_i [DEPTH],
  output logic [DW-1:0]       data_o
);

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    data_o = ram_data_i;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_i) && (ent_addr_i[head_i + PW'(i)] == ld_waddr_i)) begin
        data_o = lane_merge(data_o, ent_data_i[head_i + PW'(i)], ent_sel_i[head_i + PW'(i)]);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues MEM stores and retires them to the data RAM
// in cycles where MEM leaves the RAM port free; loads see pending bytes merged.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                clk,
  input  logic                rst,
  store_buffer_if.slave       mem,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [AW-1:0]       ram_addr_o,
  output logic [SB_LANES-1:0] ram_sel_o,
  output logic [DW-1:0]       ram_data_o,
  input  logic [DW-1:0]       ram_data_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = AW - 2;

  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WA-1:0]       ent_addr_q [DEPTH];
  logic [WA-1:0]       ent_addr_d [DEPTH];
  logic [SB_LANES-1:0] ent_sel_q  [DEPTH];
  logic [SB_LANES-1:0] ent_sel_d  [DEPTH];
  logic [DW-1:0]       ent_data_q [DEPTH];
  logic [DW-1:0]       ent_data_d [DEPTH];

  logic          is_load, is_store, empty, full;
  logic          idle_drain, coalesce, full_stall, drain, enq;
  logic [PW-1:0] young_idx;
  logic [WA-1:0] st_waddr;
  logic [DW-1:0] fwd_data;
  ram_op_e       ram_op;

  always_comb begin
    is_load    = mem.mem_ce_i && !mem.mem_we_i;
    is_store   = mem.mem_ce_i && mem.mem_we_i;
    st_waddr   = mem.mem_addr_i[AW-1:2];
    young_idx  = tail_q - PW'(1);
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));
    idle_drain = !empty && (!mem.mem_ce_i || (mem.sync_i && !is_load));
    // The youngest entry can only be the one draining when it is the sole entry.
    coalesce   = is_store && !empty && (ent_addr_q[young_idx] == st_waddr)
                 && !(idle_drain && (count_q == CW'(1)));
    full_stall = is_store && !coalesce && full;
    drain      = idle_drain || full_stall;
    enq        = is_store && !coalesce && !full;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    ent_addr_d = ent_addr_q;
    ent_sel_d  = ent_sel_q;
    ent_data_d = ent_data_q;
    if (coalesce) begin
      ent_sel_d[young_idx]  = ent_sel_q[young_idx] | mem.mem_sel_i;
      ent_data_d[young_idx] = lane_merge(ent_data_q[young_idx], mem.mem_data_i, mem.mem_sel_i);
    end
    if (enq) begin
      ent_addr_d[tail_q] = st_waddr;
      ent_sel_d[tail_q]  = mem.mem_sel_i;
      ent_data_d[tail_q] = mem.mem_data_i;
      tail_d             = tail_q + PW'(1);
    end
    if (drain) head_d = head_q + PW'(1);
    count_d = count_q + CW'(enq) - CW'(drain);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_sel_q  <= ent_sel_d;
    ent_data_q <= ent_data_d;
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ram_data_i (ram_data_i),
    .ld_waddr_i (st_waddr),
    .head_i     (head_q),
    .count_i    (count_q),
    .ent_addr_i (ent_addr_q),
    .ent_sel_i  (ent_sel_q),
    .ent_data_i (ent_data_q),
    .data_o     (fwd_data)
  );

  always_comb begin
    ram_op = RAM_IDLE;
    if (!rst) begin
      if (is_load)    ram_op = RAM_READ;
      else if (drain) ram_op = RAM_WRITE;
    end
    ram_ce_o       = (ram_op != RAM_IDLE);
    ram_we_o       = (ram_op == RAM_WRITE);
    ram_addr_o     = (ram_op == RAM_WRITE) ? {ent_addr_q[head_q], 2'b00} : mem.mem_addr_i;
    ram_sel_o      = (ram_op == RAM_WRITE) ? ent_sel_q[head_q] : mem.mem_sel_i;
    ram_data_o     = ent_data_q[head_q];
    mem.mem_data_o = (ram_op == RAM_READ) ? fwd_data : '0;
    mem.stallreq_o = !rst && (full_stall || (mem.sync_i && !empty));
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model and a golden RAM image.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.AW(32), .DW(32)) mif ();

  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mif),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  logic [31:0] tb_ram [256];
  logic [31:0] gold   [256];
  assign ram_data_i = tb_ram[ram_addr_o[9:2]];

  logic [2:0]  ctl_obs;
  logic [69:0] wr_obs;
  assign ctl_obs = {mif.stallreq_o, ram_ce_o, ram_we_o};
  assign wr_obs  = {ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o};

  typedef struct {
    logic [29:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_stall, exp_ce, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_mdata;
  logic [3:0]  exp_sel;
  logic        m_coal, m_push, m_pop;

  function automatic logic [31:0] lmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] overlay(input logic [31:0] b, input logic [31:0] u,
                                          input logic [3:0] s);
    return (b & ~lmask(s)) | (u & lmask(s));
  endfunction

  // Expected outputs for the inputs currently applied, from the queue state.
  task automatic model_eval();
    logic ld, st;
    logic [29:0] wa;
    ld = mif.mem_ce_i && !mif.mem_we_i;
    st = mif.mem_ce_i && mif.mem_we_i;
    wa = mif.mem_addr_i[31:2];
    {m_coal, m_push, m_pop} = 3'b000;
    {exp_stall, exp_ce, exp_we} = 3'b000;
    exp_addr = '0; exp_sel = '0; exp_wdata = '0; exp_mdata = '0;
    if (!rst) begin
      if (st) begin
        if (q.size() > 0 && q[$].a == wa && !(mif.sync_i && q.size() == 1)) m_coal = 1'b1;
        else if (q.size() < DEPTH) m_push = 1'b1;
        else begin exp_stall = 1'b1; m_pop = 1'b1; end
      end
      if (q.size() > 0 && (!mif.mem_ce_i || (mif.sync_i && !ld))) m_pop = 1'b1;
      if (mif.sync_i && q.size() > 0) exp_stall = 1'b1;
      if (ld) begin
        exp_ce = 1'b1;
        exp_addr = mif.mem_addr_i;
        exp_mdata = gold[mif.mem_addr_i[9:2]];
        foreach (q[i]) if (q[i].a == wa) exp_mdata = overlay(exp_mdata, q[i].d, q[i].s);
      end else if (m_pop) begin
        exp_ce = 1'b1; exp_we = 1'b1;
        exp_addr = {q[0].a, 2'b00}; exp_sel = q[0].s; exp_wdata = q[0].d;
      end
    end
  endtask

  task automatic model_commit();
    ent_t e;
    if (rst) begin
      q.delete();
      return;
    end
    if (m_coal) begin
      e = q[$];
      e.s = e.s | mif.mem_sel_i;
      e.d = overlay(e.d, mif.mem_data_i, mif.mem_sel_i);
      q[q.size()-1] = e;
    end
    if (m_push) begin
      e.a = mif.mem_addr_i[31:2]; e.s = mif.mem_sel_i; e.d = mif.mem_data_i;
      q.push_back(e);
    end
    if (m_pop) begin
      gold[q[0].a[7:0]] = overlay(gold[q[0].a[7:0]], q[0].d, q[0].s);
      void'(q.pop_front());
    end
  endtask

  task automatic cyc_set(input logic c, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input logic sy);
    mif.mem_ce_i = c; mif.mem_we_i = w; mif.mem_addr_i = a;
    mif.mem_sel_i = s; mif.mem_data_i = d; mif.sync_i = sy;
    #1;
    model_eval();
  endtask

  // Clock edge: the bench RAM takes whatever write the DUT presented.
  task automatic cyc_tick();
    logic w;
    logic [31:0] wa, wd;
    logic [3:0] ws;
    w = ram_ce_o && ram_we_o; wa = ram_addr_o; wd = ram_data_o; ws = ram_sel_o;
    @(posedge clk);
    model_commit();
    if (w) tb_ram[wa[9:2]] = overlay(tb_ram[wa[9:2]], wd, ws);
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    tb_ram[a[9:2]] = d;
    gold[a[9:2]]   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc_set(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1);
    n_tests++;
    if ({ctl_obs, mif.mem_data_o} !== 35'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {ctl_obs, mif.mem_data_o});
    end
    cyc_tick();
    rst = 1'b0;
    cyc_set(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0);
    n_tests++;
    if (ctl_obs !== 3'b000) begin
      n_fail++; $display("FAIL reset_store_accept: got %b want 000", ctl_obs);
    end
    cyc_tick();
    idle_cyc();
    n_tests++;
    if ({mif.stallreq_o, wr_obs} !== {1'b0, 2'b11, 32'h100, 4'hF, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL reset_store_write: got %h want %h", {mif.stallreq_o, wr_obs},
                         {1'b0, 2'b11, 32'h100, 4'hF, 32'hDEADBEEF});
    end
    cyc_tick();
    idle_cyc();
    n_tests++;
    if (ctl_obs !== 3'b000) begin
      n_fail++; $display("FAIL reset_store_empty: got %b want 000", ctl_obs);
    end
    cyc_tick();
  endtask

  task automatic test_forward();
    preload(32'h200, 32'h11223344);
    cyc_set(1'b1, 1'b1, 32'h203, 4'b1000, 32'hAA000000, 1'b0);
    cyc_tick();
    for (int k = 0; k < 2; k++) begin
      cyc_set(1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b0);
      n_tests++;
      if ({ctl_obs, ram_addr_o, mif.mem_data_o} !== {3'b010, 32'h200, 32'hAA223344}) begin
        n_fail++; $display("FAIL fwd_load%0d: got %h want %h", k,
                           {ctl_obs, ram_addr_o, mif.mem_data_o}, {3'b010, 32'h200, 32'hAA223344});
      end
      cyc_tick();
    end
    idle_cyc();
    n_tests++;
    if (wr_obs !== {2'b11, 32'h200, 4'b1000, 32'hAA000000}) begin
      n_fail++; $display("FAIL fwd_drain: got %h want %h", wr_obs, {2'b11, 32'h200, 4'b1000, 32'hAA000000});
    end
    cyc_tick();
    cyc_set(1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b0);
    n_tests++;
    if (mif.mem_data_o !== 32'hAA223344) begin
      n_fail++; $display("FAIL fwd_after_drain: got %h want AA223344", mif.mem_data_o);
    end
    cyc_tick();
  endtask

  task automatic test_coalesce();
    cyc_set(1'b1, 1'b1, 32'h300, 4'b0011, 32'h0000BEEF, 1'b0);
    cyc_tick();
    cyc_set(1'b1, 1'b1, 32'h302, 4'b1100, 32'hCAFE0000, 1'b0);
    cyc_tick();
    idle_cyc();
    n_tests++;
    if (wr_obs !== {2'b11, 32'h300, 4'hF, 32'hCAFEBEEF}) begin
      n_fail++; $display("FAIL coalesce_write: got %h want %h", wr_obs, {2'b11, 32'h300, 4'hF, 32'hCAFEBEEF});
    end
    cyc_tick();
    idle_cyc();
    n_tests++;
    if (ctl_obs !== 3'b000) begin
      n_fail++; $display("FAIL coalesce_single: got %b want 000", ctl_obs);
    end
    cyc_tick();
  endtask

  task automatic test_full_stall();
    for (int k = 0; k < 4; k++) begin
      cyc_set(1'b1, 1'b1, 32'(k * 4), 4'hF, 32'h1000 + 32'(k), 1'b0);
      n_tests++;
      if (ctl_obs !== 3'b000) begin
        n_fail++; $display("FAIL full_fill%0d: got %b want 000", k, ctl_obs);
      end
      cyc_tick();
    end
    cyc_set(1'b1, 1'b1, 32'h10, 4'hF, 32'h1004, 1'b0);
    n_tests++;
    if ({mif.stallreq_o, wr_obs} !== {1'b1, 2'b11, 32'h0, 4'hF, 32'h1000}) begin
      n_fail++; $display("FAIL full_stall: got %h want %h", {mif.stallreq_o, wr_obs},
                         {1'b1, 2'b11, 32'h0, 4'hF, 32'h1000});
    end
    cyc_tick();
    cyc_set(1'b1, 1'b1, 32'h10, 4'hF, 32'h1004, 1'b0);
    n_tests++;
    if (ctl_obs !== 3'b000) begin
      n_fail++; $display("FAIL full_accept: got %b want 000", ctl_obs);
    end
    cyc_tick();
    for (int k = 1; k <= 4; k++) begin
      idle_cyc();
      n_tests++;
      if (wr_obs !== {2'b11, 32'(k * 4), 4'hF, 32'h1000 + 32'(k)}) begin
        n_fail++; $display("FAIL full_order%0d: got %h want %h", k, wr_obs,
                           {2'b11, 32'(k * 4), 4'hF, 32'h1000 + 32'(k)});
      end
      cyc_tick();
    end
  endtask

  task automatic test_sync();
    for (int k = 0; k < 3; k++) begin
      cyc_set(1'b1, 1'b1, 32'h40 + 32'(k * 4), 4'hF, 32'h5000 + 32'(k), 1'b0);
      cyc_tick();
    end
    for (int k = 0; k < 4; k++) begin
      cyc_set(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      n_tests++;
      if (k < 3 && {mif.stallreq_o, wr_obs} !== {1'b1, 2'b11, 32'h40 + 32'(k * 4), 4'hF, 32'h5000 + 32'(k)}) begin
        n_fail++; $display("FAIL sync_drain%0d: got %h want %h", k, {mif.stallreq_o, wr_obs},
                           {1'b1, 2'b11, 32'h40 + 32'(k * 4), 4'hF, 32'h5000 + 32'(k)});
      end
      if (k == 3 && ctl_obs !== 3'b000) begin
        n_fail++; $display("FAIL sync_release: got %b want 000", ctl_obs);
      end
      cyc_tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) preload(32'h60 + 32'(k * 4), 32'h0BAD0000 + 32'(k));
    for (int k = 0; k < 3; k++) begin
      cyc_set(1'b1, 1'b1, 32'h60 + 32'(k * 4), 4'hF, 32'h77770000 + 32'(k), 1'b0);
      cyc_tick();
    end
    rst = 1'b1;
    idle_cyc();
    n_tests++;
    if ({ctl_obs, mif.mem_data_o} !== 35'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0", {ctl_obs, mif.mem_data_o});
    end
    cyc_tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle_cyc();
      n_tests++;
      if (ctl_obs !== 3'b000) begin
        n_fail++; $display("FAIL rstmid_idle%0d: got %b want 000", k, ctl_obs);
      end
      cyc_tick();
    end
    for (int k = 0; k < 3; k++) begin
      cyc_set(1'b1, 1'b0, 32'h60 + 32'(k * 4), 4'hF, 32'h0, 1'b0);
      n_tests++;
      if (mif.mem_data_o !== 32'h0BAD0000 + 32'(k)) begin
        n_fail++; $display("FAIL rstmid_load%0d: got %h want %h", k, mif.mem_data_o, 32'h0BAD0000 + 32'(k));
      end
      cyc_tick();
    end
  endtask

  task automatic test_random();
    logic c, w, sy;
    logic [31:0] a;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      c   = ($urandom_range(0, 99) < 70);
      w   = $urandom_range(0, 1) == 1;
      sy  = ($urandom_range(0, 99) < 8);
      a   = 32'h80 + 32'($urandom_range(0, 23));
      cyc_set(c, w, a, 4'($urandom_range(1, 15)), $urandom, sy);
      n_tests++;
      if (ctl_obs !== {exp_stall, exp_ce, exp_we}) begin
        n_fail++; $display("FAIL rand_ctl@%0d: got %b want %b", n, ctl_obs, {exp_stall, exp_ce, exp_we});
      end
      n_tests++;
      if (mif.mem_data_o !== exp_mdata) begin
        n_fail++; $display("FAIL rand_load@%0d: got %h want %h", n, mif.mem_data_o, exp_mdata);
      end
      if (exp_ce) begin
        n_tests++;
        if ({ram_addr_o, exp_we ? ram_sel_o : 4'h0, ram_data_o & lmask(exp_we ? ram_sel_o : 4'h0)}
            !== {exp_addr, exp_sel, exp_wdata & lmask(exp_sel)}) begin
          n_fail++; $display("FAIL rand_port@%0d: got %h/%h/%h want %h/%h/%h", n,
                             ram_addr_o, ram_sel_o, ram_data_o, exp_addr, exp_sel, exp_wdata);
        end
      end
      cyc_tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_ram[i] = 32'h0;
      gold[i]   = 32'h0;
    end
    test_reset();
    test_forward();
    test_coalesce();
    test_full_stall();
    test_sync();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
